// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Framed serial-to-parallel loader for the nanoV CPU clock domain.
//   Takes LANES bits per enabled beat. It can optionally hunt for a
//   start-of-frame marker before taking any beat. Beats are counted to word
//   boundaries, and each completed WIDTH-bit word goes to a holding register
//   with a valid/ready handshake.
//
// Ports
//   cpu_clk      clock, all state on the rising edge
//   rstn         asynchronous active-low reset
//   in_en        in_data / in_sof are valid this cycle
//   in_sof       start of frame, qualified by in_en
//   in_data      LANES-bit serial beat
//   out_word     holding register
//   out_valid    out_word holds an unconsumed word
//   out_ready    consumer takes out_word when out_valid & out_ready
//   live_word    raw shift register, updates on every taken beat
//   overflow     sticky: a completed word was dropped
//   short_frame  sticky: in_sof arrived mid-word
//   clr_flags    clears both sticky flags (a same-cycle set wins)
module serial_word_loader #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_MODE = 0
) (
  input  logic             cpu_clk,
  input  logic             rstn,
  input  logic             in_en,
  input  logic             in_sof,
  input  logic [LANES-1:0] in_data,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] live_word,
  output logic             overflow,
  output logic             short_frame,
  input  logic             clr_flags
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {HUNT = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   beat_idx;
  logic [CW-1:0]   cnt_nxt;
  logic [WIDTH-1:0] shifted;
  logic            sof_beat;
  logic            take;
  logic            cmpl_p0;
  logic            cmpl_p1;
  logic            short_set;
  logic            ovf_set;
  logic            load;

  generate
    if (WIDTH == LANES) begin : g_single
      assign shifted = in_data;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {live_word[WIDTH-LANES-1:0], in_data};
    end else begin : g_lsb
      assign shifted = {in_data, live_word[WIDTH-1:LANES]};
    end
  endgenerate

  // Stage p0: beat acceptance and word-boundary detection
  always_comb begin
    sof_beat  = in_en & in_sof;
    take      = in_en & ((state == SHIFT) | in_sof);
    // A start-of-frame beat is always beat 0, whatever the counter says.
    beat_idx  = sof_beat ? '0 : cnt;
    cmpl_p0   = take & (beat_idx == LAST);
    cnt_nxt   = (beat_idx == LAST) ? '0 : beat_idx + CW'(1);
    short_set = sof_beat & (state == SHIFT) & (cnt != '0);
    // The completed word sits in live_word one cycle after its final beat.
    // The handshake decision is made in that cycle.
    load      = cmpl_p1 & (~out_valid | out_ready);
    ovf_set   = cmpl_p1 & out_valid & ~out_ready;
  end

  // Stage p1: holding register, handshake and sticky flags
  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      if (SYNC_MODE != 0) state <= HUNT;
      else                state <= SHIFT;
      cnt         <= '0;
      live_word   <= '0;
      cmpl_p1     <= 1'b0;
      out_word    <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (take) begin
        live_word <= shifted;
        cnt       <= cnt_nxt;
        state     <= SHIFT;
      end
      cmpl_p1 <= cmpl_p0;

      if (load) begin
        out_word  <= live_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (short_set)      short_frame <= 1'b1;
      else if (clr_flags) short_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

  logic        cpu_clk;
  logic        rstn;
  logic [2:0]  en, sof, rdy, clr;
  logic        da, dc;
  logic [3:0]  db;

  logic [31:0] ow_a, lw_a, ow_b, lw_b, ow_c, lw_c;
  logic        ov_a, of_a, sf_a, ov_b, of_b, sf_b, ov_c, of_c, sf_c;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] xfer_q[$];

  // A: 1 lane, MSB first, free-running
  serial_word_loader #(.WIDTH(32), .LANES(1), .MSB_FIRST(1), .SYNC_MODE(0)) u_a (
    .cpu_clk(cpu_clk), .rstn(rstn), .in_en(en[0]), .in_sof(sof[0]), .in_data(da),
    .out_word(ow_a), .out_valid(ov_a), .out_ready(rdy[0]), .live_word(lw_a),
    .overflow(of_a), .short_frame(sf_a), .clr_flags(clr[0]));

  // B: 4 lanes, LSB first, free-running
  serial_word_loader #(.WIDTH(32), .LANES(4), .MSB_FIRST(0), .SYNC_MODE(0)) u_b (
    .cpu_clk(cpu_clk), .rstn(rstn), .in_en(en[1]), .in_sof(sof[1]), .in_data(db),
    .out_word(ow_b), .out_valid(ov_b), .out_ready(rdy[1]), .live_word(lw_b),
    .overflow(of_b), .short_frame(sf_b), .clr_flags(clr[1]));

  // C: 1 lane, MSB first, hunts for start of frame
  serial_word_loader #(.WIDTH(32), .LANES(1), .MSB_FIRST(1), .SYNC_MODE(1)) u_c (
    .cpu_clk(cpu_clk), .rstn(rstn), .in_en(en[2]), .in_sof(sof[2]), .in_data(dc),
    .out_word(ow_c), .out_valid(ov_c), .out_ready(rdy[2]), .live_word(lw_c),
    .overflow(of_c), .short_frame(sf_c), .clr_flags(clr[2]));

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Record every completed handshake on instance A.
  always @(posedge cpu_clk) begin
    if (ov_a && rdy[0]) xfer_q.push_back(ow_a);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic beat(input int d, input logic [3:0] data, input logic s);
    en[d]  = 1'b1;
    sof[d] = s;
    if (d == 0)      da = data[0];
    else if (d == 1) db = data;
    else             dc = data[0];
    tick();
    en[d]  = 1'b0;
    sof[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [31:0] w, input logic s);
    if (d == 1) begin
      for (int i = 0; i < 8; i++) beat(1, w[4*i +: 4], s && (i == 0));
    end else begin
      for (int i = 0; i < 32; i++) beat(d, {3'b000, w[31-i]}, s && (i == 0));
    end
  endtask

  initial begin
    rstn = 1'b0;
    en = '0; sof = '0; rdy = '0; clr = '0;
    da = 1'b0; dc = 1'b0; db = '0;
    tick();
    tick();

    // Reset state
    check("rst_live_a",  lw_a, 32'h0);
    check("rst_word_a",  ow_a, 32'h0);
    check("rst_valid_a", {31'b0, ov_a}, 32'h0);
    check("rst_flags_a", {30'b0, of_a, sf_a}, 32'h0);
    check("rst_live_b",  lw_b, 32'h0);
    check("rst_valid_c", {31'b0, ov_c}, 32'h0);
    rstn = 1'b1;
    tick();

    // 0xDEADBEEF, MSB first, one bit per beat
    rdy[0] = 1'b1;
    send_word(0, 32'hDEADBEEF, 1'b0);
    check("t1_live",        lw_a, 32'hDEADBEEF);
    check("t1_valid_early", {31'b0, ov_a}, 32'h0);
    tick();
    check("t1_valid", {31'b0, ov_a}, 32'h1);
    check("t1_word",  ow_a, 32'hDEADBEEF);
    tick();
    check("t1_valid_drop", {31'b0, ov_a}, 32'h0);
    check("t1_word_hold",  ow_a, 32'hDEADBEEF);

    // 4 lanes, LSB first: beats 1..8
    rdy[1] = 1'b1;
    for (int k = 1; k <= 8; k++) beat(1, 4'(k), 1'b0);
    check("t2_live", lw_b, 32'h87654321);
    tick();
    check("t2_valid", {31'b0, ov_b}, 32'h1);
    check("t2_word",  ow_b, 32'h87654321);
    tick();
    check("t2_valid_drop", {31'b0, ov_b}, 32'h0);
    // Same beats with idle cycles interleaved
    for (int k = 1; k <= 8; k++) begin
      beat(1, 4'(k), 1'b0);
      tick();
    end
    check("t2i_valid", {31'b0, ov_b}, 32'h1);
    check("t2i_word",  ow_b, 32'h87654321);
    check("t2i_ovf",   {31'b0, of_b}, 32'h0);

    // Overflow: consumer stalled across two words
    xfer_q.delete();
    rdy[0] = 1'b0;
    send_word(0, 32'h11111111, 1'b0);
    send_word(0, 32'h22222222, 1'b0);
    tick();
    check("t3_ovf",   {31'b0, of_a}, 32'h1);
    check("t3_word",  ow_a, 32'h11111111);
    check("t3_valid", {31'b0, ov_a}, 32'h1);
    rdy[0] = 1'b1;
    tick();
    check("t3_valid_drop", {31'b0, ov_a}, 32'h0);
    check("t3_word_hold",  ow_a, 32'h11111111);
    check("t3_xfer_n",     32'(xfer_q.size()), 32'd1);
    if (xfer_q.size() > 0) check("t3_xfer_0", xfer_q[0], 32'h11111111);
    check("t3_ovf_sticky", {31'b0, of_a}, 32'h1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("t3_ovf_clr", {31'b0, of_a}, 32'h0);

    // Frame hunting: pre-sof beats ignored
    rdy[2] = 1'b1;
    for (int i = 0; i < 5; i++) beat(2, 4'($urandom_range(0, 1)), 1'b0);
    check("t4_hunt_live", lw_c, 32'h0);
    send_word(2, 32'hCAFEF00D, 1'b1);
    tick();
    check("t4_valid", {31'b0, ov_c}, 32'h1);
    check("t4_word",  ow_c, 32'hCAFEF00D);
    check("t4_short_none", {31'b0, sf_c}, 32'h0);
    // 10 beats of a word, then a fresh sof realigns
    for (int i = 0; i < 10; i++) beat(2, {3'b000, i[0]}, 1'b0);
    send_word(2, 32'hA5A5A5A5, 1'b1);
    check("t4_short", {31'b0, sf_c}, 32'h1);
    tick();
    check("t4_realign_word",  ow_c, 32'hA5A5A5A5);
    check("t4_realign_valid", {31'b0, ov_c}, 32'h1);
    check("t4_ovf_none", {31'b0, of_c}, 32'h0);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("t4_short_clr", {31'b0, sf_c}, 32'h0);

    // Back-to-back with completion coinciding with consumption
    xfer_q.delete();
    rdy[0] = 1'b0;
    send_word(0, 32'h01234567, 1'b0);
    send_word(0, 32'h89ABCDEF, 1'b0);
    check("t5_hold_w1", ow_a, 32'h01234567);
    rdy[0] = 1'b1;
    send_word(0, 32'h0F0F0F0F, 1'b0);
    tick();
    tick();
    check("t5_xfer_n", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      check("t5_xfer_0", xfer_q[0], 32'h01234567);
      check("t5_xfer_1", xfer_q[1], 32'h89ABCDEF);
      check("t5_xfer_2", xfer_q[2], 32'h0F0F0F0F);
    end
    check("t5_ovf", {31'b0, of_a}, 32'h0);

    // Reset mid-word (after 17 beats)
    for (int i = 0; i < 17; i++) beat(0, 4'h1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_live",  lw_a, 32'h0);
    check("t6_rst_word",  ow_a, 32'h0);
    check("t6_rst_valid", {31'b0, ov_a}, 32'h0);
    check("t6_rst_flags", {30'b0, of_a, sf_a}, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    send_word(0, 32'h00008001, 1'b0);
    check("t6_live", lw_a, 32'h00008001);
    tick();
    check("t6_word",  ow_a, 32'h00008001);
    check("t6_valid", {31'b0, ov_a}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
